// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with optional first-word-fall-through read, occupancy count,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_v2 #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_ok, wr_ok;

    // Handshake: wr/rd are single-cycle requests sampled on every rising edge.
    // A read is accepted whenever data is present; a write is accepted when there
    // is room or when a same-cycle read frees a slot. Refused requests have no
    // effect other than raising the matching sticky error flag.
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd);

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q & ~clr_err;
        underflow_d = underflow_q & ~clr_err;
        if (wr_ok) w_ptr_d = w_ptr_q + 1'b1;
        if (rd_ok) r_ptr_d = r_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new error on the same edge as clr_err must not be lost.
        if (wr & full & ~rd) overflow_d = 1'b1;
        if (rd & empty)      underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) mem_q[w_ptr_q] <= w_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign r_data = mem_q[r_ptr_q];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_q;
            always_ff @(posedge clk) begin
                if (reset)      r_data_q <= '0;
                else if (rd_ok) r_data_q <= mem_q[r_ptr_q];
            end
            assign r_data = r_data_q;
        end
    endgenerate

    assign count        = count_q;
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2: a standard-read and an FWFT instance share one stimulus
// stream and are compared against a queue-based reference model.
module tb_sync_fifo_v2;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic [AW:0]   af_thresh = 5'd16, ae_thresh = 5'd2;

    logic [DW-1:0] s_r_data, f_r_data;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [AW:0]   s_count, f_count;

    sync_fifo_v2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0)) dut_std (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .w_data(w_data), .r_data(s_r_data),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .count(s_count), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
        .overflow(s_ovf), .underflow(s_udf));

    sync_fifo_v2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1)) dut_fwft (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .w_data(w_data), .r_data(f_r_data),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
        .overflow(f_ovf), .underflow(f_udf));

    always #5 clk = ~clk;

    // Reference model: FIFO contents as a queue, plus the standard-mode read register.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_std = '0;
    logic          exp_ovf = 1'b0, exp_udf = 1'b0;
    int            pass_cnt = 0, total_cnt = 0;

    task automatic step(input logic w, input logic r, input logic [DW-1:0] d,
                        input logic c, input logic rst);
        bit was_empty, was_full;
        wr = w; rd = r; w_data = d; clr_err = c; reset = rst;
        was_empty = (exp_q.size() == 0);
        was_full  = (exp_q.size() == DEPTH);
        if (rst) begin
            exp_q.delete();
            exp_std = '0;
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else begin
            exp_ovf = (w && was_full && !r) ? 1'b1 : (c ? 1'b0 : exp_ovf);
            exp_udf = (r && was_empty) ? 1'b1 : (c ? 1'b0 : exp_udf);
            if (r && !was_empty) exp_std = exp_q.pop_front();
            if (w && (!was_full || r)) exp_q.push_back(d);
        end
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        af_thresh = 5'd16; ae_thresh = 5'd2;
        step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
        total_cnt++; if (s_count !== 5'd0) $display("FAIL reset_count: got %0d exp 0", s_count); else pass_cnt++;
        total_cnt++; if (f_count !== 5'd0) $display("FAIL reset_count_fwft: got %0d exp 0", f_count); else pass_cnt++;
        total_cnt++; if (s_empty !== 1'b1) $display("FAIL reset_empty: got %b exp 1", s_empty); else pass_cnt++;
        total_cnt++; if (s_full !== 1'b0) $display("FAIL reset_full: got %b exp 0", s_full); else pass_cnt++;
        total_cnt++; if (s_ae !== 1'b1) $display("FAIL reset_almost_empty: got %b exp 1", s_ae); else pass_cnt++;
        total_cnt++; if (s_af !== 1'b0) $display("FAIL reset_almost_full: got %b exp 0", s_af); else pass_cnt++;
        total_cnt++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) $display("FAIL reset_flags: got %b%b exp 00", s_ovf, s_udf); else pass_cnt++;
        total_cnt++; if (s_r_data !== 8'h00) $display("FAIL reset_r_data: got %0h exp 0", s_r_data); else pass_cnt++;
        af_thresh = 5'd0;
        #1;
        total_cnt++; if (s_af !== 1'b1) $display("FAIL reset_af_zero: got %b exp 1", s_af); else pass_cnt++;
        af_thresh = 5'd16;
        #1;
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
        total_cnt++; if (s_full !== 1'b1) $display("FAIL fill_full: got %b exp 1", s_full); else pass_cnt++;
        total_cnt++; if (s_count !== 5'd16) $display("FAIL fill_count: got %0d exp 16", s_count); else pass_cnt++;
        step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
        total_cnt++; if (s_ovf !== 1'b1) $display("FAIL overflow_set: got %b exp 1", s_ovf); else pass_cnt++;
        total_cnt++; if (f_ovf !== 1'b1) $display("FAIL overflow_set_fwft: got %b exp 1", f_ovf); else pass_cnt++;
        total_cnt++; if (s_count !== 5'd16) $display("FAIL overflow_count: got %0d exp 16", s_count); else pass_cnt++;
    endtask

    task automatic test_drain_std();
        for (int i = 0; i < DEPTH; i++) begin
            total_cnt++; if (f_r_data !== 8'(i + 1)) $display("FAIL drain_fwft_word%0d: got %0h exp %0h", i, f_r_data, 8'(i + 1)); else pass_cnt++;
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            total_cnt++; if (s_r_data !== 8'(i + 1)) $display("FAIL drain_std_word%0d: got %0h exp %0h", i, s_r_data, 8'(i + 1)); else pass_cnt++;
        end
        total_cnt++; if (s_empty !== 1'b1) $display("FAIL drain_empty: got %b exp 1", s_empty); else pass_cnt++;
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        total_cnt++; if (s_udf !== 1'b1) $display("FAIL underflow_set: got %b exp 1", s_udf); else pass_cnt++;
        total_cnt++; if (f_udf !== 1'b1) $display("FAIL underflow_set_fwft: got %b exp 1", f_udf); else pass_cnt++;
        total_cnt++; if (s_r_data !== 8'h10) $display("FAIL underflow_hold: got %0h exp 10", s_r_data); else pass_cnt++;
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        total_cnt++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) $display("FAIL clr_err: got %b%b exp 00", s_ovf, s_udf); else pass_cnt++;
        total_cnt++; if (f_ovf !== 1'b0 || f_udf !== 1'b0) $display("FAIL clr_err_fwft: got %b%b exp 00", f_ovf, f_udf); else pass_cnt++;
    endtask

    task automatic test_full_passthrough();
        logic [DW-1:0] words [DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = 8'($urandom_range(0, 255));
            step(1'b1, 1'b0, words[i], 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        total_cnt++; if (s_r_data !== words[0]) $display("FAIL pass_oldest: got %0h exp %0h", s_r_data, words[0]); else pass_cnt++;
        total_cnt++; if (s_count !== 5'd16) $display("FAIL pass_count: got %0d exp 16", s_count); else pass_cnt++;
        total_cnt++; if (s_ovf !== 1'b0) $display("FAIL pass_no_overflow: got %b exp 0", s_ovf); else pass_cnt++;
        total_cnt++; if (f_r_data !== words[1]) $display("FAIL pass_fwft_head: got %0h exp %0h", f_r_data, words[1]); else pass_cnt++;
        for (int i = 1; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            total_cnt++; if (s_r_data !== words[i]) $display("FAIL pass_drain%0d: got %0h exp %0h", i, s_r_data, words[i]); else pass_cnt++;
        end
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        total_cnt++; if (s_r_data !== 8'hAA) $display("FAIL pass_last: got %0h exp aa", s_r_data); else pass_cnt++;
    endtask

    task automatic test_empty_both();
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        total_cnt++; if (s_count !== 5'd1) $display("FAIL eboth_count: got %0d exp 1", s_count); else pass_cnt++;
        total_cnt++; if (s_udf !== 1'b1) $display("FAIL eboth_underflow: got %b exp 1", s_udf); else pass_cnt++;
        total_cnt++; if (f_r_data !== 8'h55) $display("FAIL eboth_fwft_data: got %0h exp 55", f_r_data); else pass_cnt++;
        total_cnt++; if (s_r_data !== 8'hAA) $display("FAIL eboth_std_hold: got %0h exp aa", s_r_data); else pass_cnt++;
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        total_cnt++; if (s_r_data !== 8'h55) $display("FAIL eboth_std_read: got %0h exp 55", s_r_data); else pass_cnt++;
        total_cnt++; if (s_udf !== 1'b0) $display("FAIL eboth_clr: got %b exp 0", s_udf); else pass_cnt++;
    endtask

    task automatic test_thresholds();
        af_thresh = 5'd12; ae_thresh = 5'd3;
        for (int n = 1; n <= DEPTH; n++) begin
            step(1'b1, 1'b0, 8'(n), 1'b0, 1'b0);
            total_cnt++; if (s_ae !== (n <= 3)) $display("FAIL thr_fill_ae_n%0d: got %b exp %b", n, s_ae, (n <= 3)); else pass_cnt++;
            total_cnt++; if (f_af !== (n >= 12)) $display("FAIL thr_fill_af_n%0d: got %b exp %b", n, f_af, (n >= 12)); else pass_cnt++;
        end
        af_thresh = 5'd17; ae_thresh = 5'd16;
        #1;
        total_cnt++; if (s_af !== 1'b0) $display("FAIL thr_af_over_depth: got %b exp 0", s_af); else pass_cnt++;
        total_cnt++; if (s_ae !== 1'b1) $display("FAIL thr_ae_depth: got %b exp 1", s_ae); else pass_cnt++;
        af_thresh = 5'd12; ae_thresh = 5'd3;
        for (int n = DEPTH - 1; n >= 0; n--) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            total_cnt++; if (s_ae !== (n <= 3)) $display("FAIL thr_drain_ae_n%0d: got %b exp %b", n, s_ae, (n <= 3)); else pass_cnt++;
            total_cnt++; if (s_af !== (n >= 12)) $display("FAIL thr_drain_af_n%0d: got %b exp %b", n, s_af, (n >= 12)); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic          w, r, c;
        logic [AW:0]   esz;
        for (int cyc = 0; cyc < 240; cyc++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            c = 1'b0;
            if (cyc < 40) begin
                // Interleaved phase: never over- or under-run.
                if (exp_q.size() == DEPTH && !r) w = 1'b0;
                if (exp_q.size() == 0) r = 1'b0;
            end else begin
                c = ($urandom_range(0, 7) == 0);
                af_thresh = 5'($urandom_range(0, 17));
                ae_thresh = 5'($urandom_range(0, 17));
            end
            step(w, r, 8'($urandom_range(0, 255)), c, (cyc == 150));
            esz = 5'(exp_q.size());
            total_cnt++; if (s_count !== esz || f_count !== esz) $display("FAIL rnd_count c%0d: got %0d/%0d exp %0d", cyc, s_count, f_count, esz); else pass_cnt++;
            total_cnt++; if (s_empty !== (esz == 0) || f_full !== (esz == 16)) $display("FAIL rnd_empty_full c%0d: got %b%b exp %b%b", cyc, s_empty, f_full, (esz == 0), (esz == 16)); else pass_cnt++;
            total_cnt++; if (s_af !== (esz >= af_thresh) || f_ae !== (esz <= ae_thresh)) $display("FAIL rnd_thresh c%0d: got %b%b exp %b%b", cyc, s_af, f_ae, (esz >= af_thresh), (esz <= ae_thresh)); else pass_cnt++;
            total_cnt++; if (s_ovf !== exp_ovf || f_udf !== exp_udf) $display("FAIL rnd_flags c%0d: got %b%b exp %b%b", cyc, s_ovf, f_udf, exp_ovf, exp_udf); else pass_cnt++;
            total_cnt++; if (s_r_data !== exp_std) $display("FAIL rnd_std_data c%0d: got %0h exp %0h", cyc, s_r_data, exp_std); else pass_cnt++;
            if (esz != 0) begin
                total_cnt++; if (f_r_data !== exp_q[0]) $display("FAIL rnd_fwft_data c%0d: got %0h exp %0h", cyc, f_r_data, exp_q[0]); else pass_cnt++;
            end
        end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        total_cnt++; if (s_count !== 5'd0 || f_count !== 5'd0) $display("FAIL midreset_count: got %0d/%0d exp 0", s_count, f_count); else pass_cnt++;
        total_cnt++; if (s_empty !== 1'b1) $display("FAIL midreset_empty: got %b exp 1", s_empty); else pass_cnt++;
        total_cnt++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) $display("FAIL midreset_flags: got %b%b exp 00", s_ovf, s_udf); else pass_cnt++;
        total_cnt++; if (s_r_data !== 8'h00) $display("FAIL midreset_r_data: got %0h exp 0", s_r_data); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_std();
        test_full_passthrough();
        test_empty_both();
        test_thresholds();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
